// File: rtl/alu_pkg.sv
// Shared op-codes and FSM encoding for the multi-cycle ALU.
// No latency or backpressure of its own; constants only.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  // Two bits so that the unused codes exist and fall back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps.
// acc shows the post-step value so the caller can capture it on the last step; no backpressure.
module alu_mc_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign acc  = mplier[0] ? (acc_q + mcand) : acc_q;
  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc_q  <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc_q  <= acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB/PASS in 1 cycle, MUL in WIDTH+1 cycles via shift-add.
// busy high during MUL iterations; start while busy is dropped, no queueing.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           select,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   f
);

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] f_nxt;
  logic               done_nxt;
  logic               mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] xz, yz;

  assign xz   = {{WIDTH{1'b0}}, x};
  assign yz   = {{WIDTH{1'b0}}, y};
  assign busy = (state == ST_MUL);

  alu_mc_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mul_load),
    .step  (mul_step),
    .a     (x),
    .b     (y),
    .acc   (mul_acc),
    .last  (mul_last)
  );

  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    done_nxt  = 1'b0;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (select)
            OP_ADD:  begin f_nxt = xz + yz; done_nxt = 1'b1; end
            OP_SUB:  begin f_nxt = xz - yz; done_nxt = 1'b1; end
            OP_PASS: begin f_nxt = xz;      done_nxt = 1'b1; end
            default: begin mul_load = 1'b1; state_nxt = ST_MUL; end
          endcase
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          f_nxt     = mul_acc;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      f     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      f     <= f_nxt;
      done  <= done_nxt;
    end
  end

endmodule
